// File: rtl/sfp_ctrl_pkg.sv
// Shared types and constants for the SFP accumulate/ReLU sequencer.
// Holds the state encoding, the fixed per-state dwell lengths and small sizing helpers.
package sfp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_ACC   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RELU  = 3'd4,
      ST_WRITE = 3'd5,
      ST_DONE  = 3'd6
   } sfp_state_t;

   localparam int CLR_CYC   = 1;
   localparam int DRAIN_CYC = 1;
   localparam int RELU_CYC  = 1;

   // Wide enough to count the longest fixed-length state.
   localparam int DWELL_W = 2;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Last dwell index for the fixed-length states; other states exit on their own terms.
   function automatic logic [DWELL_W-1:0] dwell_last(input sfp_state_t s);
      case (s)
         ST_CLR:   return DWELL_W'(CLR_CYC - 1);
         ST_DRAIN: return DWELL_W'(DRAIN_CYC - 1);
         ST_RELU:  return DWELL_W'(RELU_CYC - 1);
         default:  return '0;
      endcase
   endfunction

endpackage

// File: rtl/sfp_addr_gen.sv
// Psum read address generator: a base register stepping by n_o per kernel offset,
// plus the current output position, so the sequencer never needs a multiplier.
module sfp_addr_gen
   import sfp_ctrl_pkg::*;
#(
   parameter int n_o     = 16,
   parameter int pmem_aw = 8,
   parameter int omem_aw = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               step,
   input  logic [omem_aw-1:0] o,
   output logic [pmem_aw-1:0] addr
);

   localparam logic [pmem_aw-1:0] STRIDE = pmem_aw'(n_o);

   logic [pmem_aw-1:0] base_q;
   logic [pmem_aw-1:0] base_d;

   always_comb begin
      base_d = base_q;
      if (clear) begin
         base_d = '0;
      end else if (step) begin
         base_d = base_q + STRIDE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q <= '0;
      end else begin
         base_q <= base_d;
      end
   end

   // Truncation to pmem_aw is intended; the parameter constraint keeps real addresses in range.
   assign addr = base_q + pmem_aw'(o);

endmodule

// File: rtl/sfp_seq_ctrl.sv
// Sequencer for the SFP output stage: per output position clear, accumulate all kij
// partial sums, apply ReLU, then write the result to output memory.
module sfp_seq_ctrl
   import sfp_ctrl_pkg::*;
#(
   parameter int n_kij   = 9,
   parameter int n_o     = 16,
   parameter int pmem_aw = 8,
   parameter int omem_aw = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               pmem_rd,
   output logic [pmem_aw-1:0] pmem_addr,
   output logic               sfp_clr,
   output logic               sfp_acc,
   output logic               omem_wr,
   output logic [omem_aw-1:0] omem_addr
);

   localparam int KIJ_W = cnt_w(n_kij);
   localparam logic [KIJ_W-1:0]   KIJ_LAST = KIJ_W'(n_kij - 1);
   localparam logic [omem_aw-1:0] O_LAST   = omem_aw'(n_o - 1);

   sfp_state_t state_q;
   sfp_state_t state_d;

   logic [KIJ_W-1:0]   kij_q;
   logic [KIJ_W-1:0]   kij_d;
   logic [omem_aw-1:0] o_q;
   logic [omem_aw-1:0] o_d;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_d;

   logic               kij_last;
   logic               o_last;
   logic               fixed_last;
   logic [pmem_aw-1:0] gen_addr;

   assign kij_last   = (kij_q == KIJ_LAST);
   assign o_last     = (o_q == O_LAST);
   assign fixed_last = (dwell_q == dwell_last(state_q));

   sfp_addr_gen #(
      .n_o     (n_o),
      .pmem_aw (pmem_aw),
      .omem_aw (omem_aw)
   ) u_addr_gen (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == ST_CLR),
      .step  (state_q == ST_ACC),
      .o     (o_q),
      .addr  (gen_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)      state_d = ST_CLR;
         ST_CLR:   if (fixed_last) state_d = ST_ACC;
         ST_ACC:   if (kij_last)   state_d = ST_DRAIN;
         ST_DRAIN: if (fixed_last) state_d = ST_RELU;
         ST_RELU:  if (fixed_last) state_d = ST_WRITE;
         ST_WRITE: state_d = o_last ? ST_DONE : ST_CLR;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Counters: kij restarts for every output position, o only when the tile begins.
   always_comb begin
      kij_d   = kij_q;
      o_d     = o_q;
      dwell_d = '0;
      case (state_q)
         ST_IDLE: begin
            kij_d = '0;
            o_d   = '0;
         end
         ST_CLR: begin
            kij_d   = '0;
            dwell_d = fixed_last ? '0 : dwell_q + DWELL_W'(1);
         end
         ST_ACC: begin
            if (!kij_last) begin
               kij_d = kij_q + KIJ_W'(1);
            end
         end
         ST_DRAIN, ST_RELU: begin
            dwell_d = fixed_last ? '0 : dwell_q + DWELL_W'(1);
         end
         ST_WRITE: begin
            if (!o_last) begin
               o_d = o_q + omem_aw'(1);
            end
         end
         default: begin
            kij_d = kij_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kij_q   <= '0;
         o_q     <= '0;
         dwell_q <= '0;
      end else begin
         kij_q   <= kij_d;
         o_q     <= o_d;
         dwell_q <= dwell_d;
      end
   end

   // The SFP consumes read data one cycle late, so kij=0 reads but does not accumulate.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = 1'b0;
      pmem_rd   = 1'b0;
      pmem_addr = '0;
      sfp_clr   = 1'b0;
      sfp_acc   = 1'b0;
      omem_wr   = 1'b0;
      omem_addr = '0;
      case (state_q)
         ST_CLR: sfp_clr = 1'b1;
         ST_ACC: begin
            pmem_rd   = 1'b1;
            pmem_addr = gen_addr;
            sfp_acc   = (kij_q != '0);
         end
         ST_DRAIN: sfp_acc = 1'b1;
         ST_WRITE: begin
            omem_wr   = 1'b1;
            omem_addr = o_q;
         end
         ST_DONE: done = 1'b1;
         default: done = 1'b0;
      endcase
   end

   a_clr_acc_excl: assert property (@(posedge clk) disable iff (reset) !(sfp_clr && sfp_acc));

endmodule
